fetch_stage: RTL and testbench

- Instruction-fetch stage of the ARM pipelined core.
- Holds the program counter and drives the word-addressed instruction memory, which returns `imem_rd` combinationally from `imem_addr`.
- Captures the returned word into the IF/ID pipeline register and feeds the decode stage.
- Handles decode stalls, decode flushes and branch/PC-write redirects from execute.

---
 rtl/core_pkg.sv | 24 ++
 rtl/fetch_stage_pc_register.sv | 26 ++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the pipelined ARM core front end.
package core_pkg;

   localparam int WORD = 32;

   // MOV R0,R0: the architectural no-op used as a pipeline bubble.
   localparam logic [WORD-1:0] NOP_INSTR = 32'hE1A0_0000;
   localparam logic [WORD-1:0] RESET_PC  = 32'h0000_0000;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic [WORD-1:0] instr;
      logic [WORD-1:0] pc;
      logic [WORD-1:0] pc_plus8;
      logic            valid;
   } ifid_t;

   // Fetch fault tracking: once a fetch leaves the legal range the flag sticks.
   typedef enum logic {
      FS_RUN   = 1'b0,
      FS_FAULT = 1'b1
   } fault_state_t;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: synchronous reset, load beats advance, advance steps one word.
module pc_register
   import core_pkg::*;
#(
   parameter logic [WORD-1:0] RESET_VALUE = core_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            load,
   input  logic [WORD-1:0] load_value,
   output logic [WORD-1:0] q
);

   // PC update: reset, then load, then sequential advance (wraps modulo 2^32).
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VALUE;
      end else if (load) begin
         q <= load_value;
      end else if (en) begin
         q <= q + WORD'(4);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction memory address, IF/ID register,
// sticky out-of-range fault flag and a count of captured instructions.
module fetch_stage
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = core_pkg::RESET_PC,
   parameter int          IMEM_WORDS = 64,
   parameter logic [31:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        flush_d,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus8_d,
   output logic        valid_d,
   output logic        fetch_fault,
   output logic [15:0] fetch_count
);

   localparam logic [WORD-1:0] PC_LIMIT = WORD'(IMEM_WORDS) << 2;

   logic [WORD-1:0] pc_q;
   logic            in_range;
   logic            squash;
   logic            capture;
   ifid_t           ifid_q;
   ifid_t           ifid_next;
   fault_state_t    state_q;
   fault_state_t    state_next;

   // Redirect targets are forced word aligned; the low bits are dropped silently.
   pc_register #(
      .RESET_VALUE(RESET_PC)
   ) u_pc (
      .clk        (clk),
      .reset      (reset),
      .en         (!stall_f),
      .load       (redirect),
      .load_value (redirect_target & ~WORD'(3)),
      .q          (pc_q)
   );

   assign imem_addr = pc_q;
   assign in_range  = (pc_q < PC_LIMIT);
   assign squash    = redirect | flush_d;
   assign capture   = !squash && !stall_f;

   // IF/ID next value: squash to a bubble, hold on stall, else capture the fetch.
   always_comb begin
      ifid_next = ifid_q;
      if (squash) begin
         ifid_next.instr    = NOP_INSTR;
         ifid_next.pc       = pc_q;
         ifid_next.pc_plus8 = pc_q + WORD'(8);
         ifid_next.valid    = 1'b0;
      end else if (!stall_f) begin
         ifid_next.instr    = in_range ? imem_rd : NOP_INSTR;
         ifid_next.pc       = pc_q;
         ifid_next.pc_plus8 = pc_q + WORD'(8);
         ifid_next.valid    = in_range;
      end
   end

   // IF/ID pipeline register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_q.instr    <= NOP_INSTR;
         ifid_q.pc       <= '0;
         ifid_q.pc_plus8 <= WORD'(8);
         ifid_q.valid    <= 1'b0;
      end else begin
         ifid_q <= ifid_next;
      end
   end

   // Fault tracking state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FS_RUN;
      end else begin
         state_q <= state_next;
      end
   end

   // Fault next state: enter FAULT on the first out-of-range capture, leave only on reset.
   always_comb begin
      state_next = state_q;
      if (state_q == FS_RUN && capture && !in_range) begin
         state_next = FS_FAULT;
      end
   end

   // Count valid captures, saturating at all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (capture && in_range && fetch_count != 16'hFFFF) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end

   assign instr_d     = ifid_q.instr;
   assign pc_d        = ifid_q.pc;
   assign pc_plus8_d  = ifid_q.pc_plus8;
   assign valid_d     = ifid_q.valid;
   assign fetch_fault = (state_q == FS_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_f = 1'b0;
   logic        flush_d = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus8_d;
   logic        valid_d;
   logic        fetch_fault;
   logic [15:0] fetch_count;

   logic [31:0] mem [0:63];

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // behavioural model state
   logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
   logic        m_valid, m_fault;
   int          m_cnt;

   always #5 clk = ~clk;

   assign imem_rd = mem[imem_addr[7:2]];

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_WORDS (64),
      .NOP_INSTR  (32'hE1A0_0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall_f         (stall_f),
      .flush_d         (flush_d),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_rd         (imem_rd),
      .instr_d         (instr_d),
      .pc_d            (pc_d),
      .pc_plus8_d      (pc_plus8_d),
      .valid_d         (valid_d),
      .fetch_fault     (fetch_fault),
      .fetch_count     (fetch_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model by the fetch rules, compare all outputs.
   task automatic cycle(input logic r, input logic s, input logic f,
                        input logic rd, input logic [31:0] tgt);
      logic [31:0] n_pc, n_instr, n_pcd, n_pc8;
      logic        n_valid, n_fault;
      int          n_cnt;
      reset = r; stall_f = s; flush_d = f; redirect = rd; redirect_target = tgt;
      if (r) begin
         n_pc = 32'h0; n_instr = NOP; n_pcd = 32'h0; n_pc8 = 32'h8;
         n_valid = 1'b0; n_fault = 1'b0; n_cnt = 0;
      end else begin
         n_instr = m_instr; n_pcd = m_pcd; n_pc8 = m_pc8;
         n_valid = m_valid; n_fault = m_fault; n_cnt = m_cnt;
         if (rd)      n_pc = (tgt / 4) * 4;
         else if (s)  n_pc = m_pc;
         else         n_pc = m_pc + 32'd4;
         if (rd || f) begin
            n_instr = NOP; n_valid = 1'b0; n_pcd = m_pc; n_pc8 = m_pc + 32'd8;
         end else if (!s) begin
            n_pcd = m_pc; n_pc8 = m_pc + 32'd8;
            if (m_pc < 32'd256) begin
               n_instr = mem[m_pc / 4]; n_valid = 1'b1;
               if (n_cnt < 65535) n_cnt = n_cnt + 1;
            end else begin
               n_instr = NOP; n_valid = 1'b0; n_fault = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pc8 = n_pc8;
      m_valid = n_valid; m_fault = n_fault; m_cnt = n_cnt;
      $display("cyc %0d rst=%0b st=%0b fl=%0b rd=%0b tgt=%h -> addr=%h instr=%h pc_d=%h v=%0b flt=%0b cnt=%0d",
               cyc, r, s, f, rd, tgt, imem_addr, instr_d, pc_d, valid_d, fetch_fault, fetch_count);
      check("imem_addr", imem_addr, m_pc);
      check("instr_d", instr_d, m_instr);
      check("pc_d", pc_d, m_pcd);
      check("pc_plus8_d", pc_plus8_d, m_pc8);
      check("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
      check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      check("fetch_count", {16'b0, fetch_count}, 32'(m_cnt));
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_addr"}, imem_addr, 32'h0);
      check({tag, "_instr"}, instr_d, NOP);
      check({tag, "_pc_d"}, pc_d, 32'h0);
      check({tag, "_pc8"}, pc_plus8_d, 32'h8);
      check({tag, "_valid"}, {31'b0, valid_d}, 32'h0);
      check({tag, "_fault"}, {31'b0, fetch_fault}, 32'h0);
      check({tag, "_count"}, {16'b0, fetch_count}, 32'h0);
   endtask

   initial begin
      logic [31:0] words [0:3];
      words[0] = 32'hE3A0500F; words[1] = 32'hE1A06285;
      words[2] = 32'hE0867005; words[3] = 32'hE3A0F000;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = words[i];
      m_pc = '0; m_instr = NOP; m_pcd = '0; m_pc8 = 32'h8;
      m_valid = 1'b0; m_fault = 1'b0; m_cnt = 0;

      @(negedge clk);

      // reset and free run over words 0..3
      cycle(1, 0, 0, 0, 32'h0);
      check_reset_values("reset");
      for (int k = 0; k < 4; k++) begin
         cycle(0, 0, 0, 0, 32'h0);
         check("run_instr", instr_d, words[k]);
         check("run_pc8", pc_plus8_d, 32'h8 + 32'(4 * k));
         check("run_valid", {31'b0, valid_d}, 32'h1);
      end
      check("run_count", {16'b0, fetch_count}, 32'd4);

      // stall at pc 8
      cycle(1, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      check("pre_stall_addr", imem_addr, 32'h8);
      for (int k = 0; k < 2; k++) begin
         cycle(0, 1, 0, 0, 32'h0);
         check("stall_addr", imem_addr, 32'h8);
         check("stall_instr", instr_d, 32'hE1A06285);
         check("stall_count", {16'b0, fetch_count}, 32'd2);
      end

      // redirect to unaligned 6 while stalled
      cycle(0, 1, 0, 1, 32'h6);
      check("redir_addr", imem_addr, 32'h4);
      check("redir_instr", instr_d, NOP);
      check("redir_valid", {31'b0, valid_d}, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      check("after_redir_instr", instr_d, 32'hE1A06285);
      check("after_redir_valid", {31'b0, valid_d}, 32'h1);

      // flush at pc C
      cycle(0, 0, 0, 0, 32'h0);
      check("pre_flush_addr", imem_addr, 32'hC);
      cycle(0, 0, 1, 0, 32'h0);
      check("flush_instr", instr_d, NOP);
      check("flush_valid", {31'b0, valid_d}, 32'h0);
      check("flush_addr", imem_addr, 32'h10);
      cycle(0, 0, 0, 0, 32'h0);
      check("post_flush_pc_d", pc_d, 32'h10);

      // out-of-range fetch and sticky fault
      cycle(0, 0, 0, 1, 32'h100);
      check("oor_addr", imem_addr, 32'h100);
      cycle(0, 0, 0, 0, 32'h0);
      check("oor_valid", {31'b0, valid_d}, 32'h0);
      check("oor_fault", {31'b0, fetch_fault}, 32'h1);
      check("oor_instr", instr_d, NOP);
      cycle(0, 0, 0, 1, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      check("sticky_fault", {31'b0, fetch_fault}, 32'h1);

      // PC wrap at the top of the address space
      cycle(0, 0, 0, 1, 32'hFFFF_FFFE);
      check("top_addr", imem_addr, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_pc8", pc_plus8_d, 32'h4);

      // reset beats a simultaneous redirect and stall
      cycle(1, 1, 0, 1, 32'h20);
      check_reset_values("reset_redir");

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic        r, s, f, rd;
         logic [31:0] tgt;
         r   = ($urandom_range(0, 49) == 0);
         s   = ($urandom_range(0, 3) == 0);
         f   = ($urandom_range(0, 5) == 0);
         rd  = ($urandom_range(0, 7) == 0);
         tgt = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255));
         cycle(r, s, f, rd, tgt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time bound so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
